// File: rtl/v_add_pkg.sv
// Shared constants, state encoding and saturation limits for the lane-serial vector adder.
package v_add_pkg;

    localparam int V_LANE_W = 16;
    localparam int V_LANES  = 8;

    localparam logic [V_LANE_W-1:0] V_SAT_MAX = 16'h7FFF;
    localparam logic [V_LANE_W-1:0] V_SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } v_add_state_t;

endpackage

// File: rtl/full_adder_16.sv
// 16-bit ripple-style adder with carry-in and carry-out; the shared lane adder.
module full_adder_16
    import v_add_pkg::*;
(
    input  logic [V_LANE_W-1:0] a,
    input  logic [V_LANE_W-1:0] b,
    input  logic                cin,
    output logic [V_LANE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{V_LANE_W{1'b0}}, cin};

endmodule

// File: rtl/v_add_seq.sv
// Lane-serial vector add/subtract sequencer: one lane per cycle through one 16-bit adder.
// Optional build macro V_ADD_SAT_EN clamps overflowing lanes to 16'h7FFF / 16'h8000.
module v_add_seq
    import v_add_pkg::*;
#(
    parameter int LANES = V_LANES,
    parameter int W     = V_LANE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op_sub,
    input  logic [LANES*W-1:0] va,
    input  logic [LANES*W-1:0] vb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] vsum,
    output logic [LANES-1:0]   ovf_mask
);

    localparam int            IW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    v_add_state_t       state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [LANES*W-1:0] a_q, a_d;
    logic [LANES*W-1:0] b_q, b_d;
    logic               sub_q, sub_d;
    logic [LANES*W-1:0] vsum_q, vsum_d;
    logic [LANES-1:0]   ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               accept;

    logic [W-1:0]       lane_a, lane_b, lane_bx, lane_sum, lane_res;
    logic               lane_cout, lane_ovf;

    always_comb begin
        lane_a  = a_q[int'(idx_q)*W +: W];
        lane_b  = b_q[int'(idx_q)*W +: W];
        lane_bx = sub_q ? ~lane_b : lane_b;
    end

    full_adder_16 u_lane_adder (
        .a    (lane_a),
        .b    (lane_bx),
        .cin  (sub_q),
        .sum  (lane_sum),
        .cout (lane_cout)
    );

    // Carry into the sign bit differing from carry out is exactly the
    // "equal operand signs, different result sign" overflow condition.
    always_comb begin
        lane_ovf = lane_cout ^ (lane_a[W-1] ^ lane_bx[W-1] ^ lane_sum[W-1]);
`ifdef V_ADD_SAT_EN
        lane_res = lane_ovf ? (lane_a[W-1] ? V_SAT_MIN : V_SAT_MAX) : lane_sum;
`else
        lane_res = lane_sum;
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        vsum_d   = vsum_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            RUN: begin
                vsum_d[int'(idx_q)*W +: W] = lane_res;
                ovf_d[idx_q]               = lane_ovf;
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                    accept  = in_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new pair can arrive from IDLE or on the same edge the result leaves DONE.
        if (accept) begin
            a_d     = va;
            b_d     = vb;
            sub_d   = op_sub;
            idx_d   = '0;
            state_d = RUN;
        end

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            vsum_q      <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            vsum_q      <= vsum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign vsum      = vsum_q;
    assign ovf_mask  = ovf_q;

endmodule
